// File: rtl/stream_mux_2to1_rr.sv
// Two-source valid/ready merge with round-robin arbitration into a single
// registered output slot; out_sel_o tags each word with the source it came from.
module stream_mux_2to1_rr #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in0_valid_i,
    output logic             in0_ready_o,
    input  logic [WIDTH-1:0] in0_data_i,
    input  logic             in1_valid_i,
    output logic             in1_ready_o,
    input  logic [WIDTH-1:0] in1_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_sel_o
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_sel_q, out_sel_d;
    logic             last_grant_q, last_grant_d;

    logic             load_en;
    logic             grant_vld;
    logic             grant;
    logic             accept;

    // Resetting last_grant to 1 makes in0 the winner of the first contention.
    always_comb begin
        load_en   = !out_valid_q || out_ready_i;
        grant_vld = in0_valid_i || in1_valid_i;
        if (in0_valid_i && in1_valid_i) begin
            grant = ~last_grant_q;
        end else begin
            grant = in1_valid_i;
        end
        accept      = load_en && grant_vld;
        in0_ready_o = load_en && in0_valid_i && !grant;
        in1_ready_o = load_en && in1_valid_i && grant;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = grant ? in1_data_i : in0_data_i;
            out_sel_d    = grant;
            last_grant_d = grant;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sel_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_2to1_rr.sv
// Bench for stream_mux_2to1_rr: expected {sel,data} words queued as stimulus is
// driven, compared in order whenever the output handshakes.
module tb_stream_mux_2to1_rr;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in0_valid, in0_ready;
    logic [WIDTH-1:0] in0_data;
    logic             in1_valid, in1_ready;
    logic [WIDTH-1:0] in1_data;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;

    int errors = 0;
    int checks = 0;
    logic [WIDTH:0] sb[$];

    stream_mux_2to1_rr #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in0_valid_i (in0_valid),
        .in0_ready_o (in0_ready),
        .in0_data_i  (in0_data),
        .in1_valid_i (in1_valid),
        .in1_ready_o (in1_ready),
        .in1_data_i  (in1_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_sel_o   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output scoreboard: a word leaving the slot must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [WIDTH:0] exp_w;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got sel=%0d data=%02h, required no output", out_sel, out_data);
            end else begin
                exp_w = sb.pop_front();
                if ({out_sel, out_data} !== exp_w) begin
                    errors++;
                    $display("FAIL sb_word: got sel=%0d data=%02h, required sel=%0d data=%02h",
                             out_sel, out_data, exp_w[WIDTH], exp_w[WIDTH-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d words still pending, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        sb.delete();
        step();
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_sel, in0_ready, in1_ready} !== '0) begin
            errors++;
            $display("FAIL reset_held: got v=%0d d=%02h s=%0d r0=%0d r1=%0d, required all 0",
                     out_valid, out_data, out_sel, in0_ready, in1_ready);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_sel, in0_ready, in1_ready} !== '0) begin
            errors++;
            $display("FAIL reset_release: got v=%0d d=%02h s=%0d r0=%0d r1=%0d, required all 0",
                     out_valid, out_data, out_sel, in0_ready, in1_ready);
        end
        step();
    endtask

    task automatic test_in0_only();
        in0_valid = 1'b1;
        in0_data  = 8'hA5;
        out_ready = 1'b1;
        sb.push_back({1'b0, 8'hA5});
        @(negedge clk);
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL in0_ready: got r0=%0d r1=%0d, required r0=1 r1=0", in0_ready, in1_ready);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 1'b0) begin
            errors++;
            $display("FAIL in0_latency: got v=%0d d=%02h s=%0d, required v=1 d=a5 s=0",
                     out_valid, out_data, out_sel);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL in0_drain: got out_valid=%0d, required 0", out_valid);
        end
        check_empty("in0_only_done");
        step();
    endtask

    task automatic test_contention();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'h11;
        in1_data  = 8'h22;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back((k % 2 == 0) ? {1'b0, 8'h11} : {1'b1, 8'h22});
            @(negedge clk);
            checks++;
            if (in0_ready !== (k % 2 == 0) || in1_ready !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got r0=%0d r1=%0d, required r0=%0d r1=%0d",
                         k, in0_ready, in1_ready, (k % 2 == 0), (k % 2 == 1));
            end
            step();
        end
        idle_inputs();
        step();
        step();
        @(negedge clk);
        check_empty("contention_done");
        step();
    endtask

    task automatic test_backpressure();
        in1_valid = 1'b1;
        in1_data  = 8'h3C;
        out_ready = 1'b1;
        sb.push_back({1'b1, 8'h3C});
        @(negedge clk);
        checks++;
        if (in1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_load: got in1_ready=%0d, required 1", in1_ready);
        end
        step();
        in0_valid = 1'b1;
        in0_data  = 8'h44;
        in1_data  = 8'h55;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 1'b1 ||
                in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got v=%0d d=%02h s=%0d r0=%0d r1=%0d, required v=1 d=3c s=1 r0=0 r1=0",
                         k, out_valid, out_data, out_sel, in0_ready, in1_ready);
            end
            step();
        end
        out_ready = 1'b1;
        sb.push_back({1'b0, 8'h44});
        @(negedge clk);
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got r0=%0d r1=%0d, required r0=1 r1=0", in0_ready, in1_ready);
        end
        step();
        idle_inputs();
        step();
        @(negedge clk);
        check_empty("backpressure_done");
        step();
    endtask

    task automatic test_reset_mid_stall();
        in1_valid = 1'b1;
        in1_data  = 8'h3C;
        out_ready = 1'b1;
        sb.push_back({1'b1, 8'h3C});
        step();
        idle_inputs();
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            errors++;
            $display("FAIL rst_stall_pre: got v=%0d d=%02h, required v=1 d=3c", out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got v=%0d d=%02h s=%0d, required v=0 d=00 s=0",
                     out_valid, out_data, out_sel);
        end
        step();
        step();
        rst_n = 1'b1;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'h11;
        in1_data  = 8'h22;
        out_ready = 1'b1;
        sb.push_back({1'b0, 8'h11});
        @(negedge clk);
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_rr_restart: got r0=%0d r1=%0d, required r0=1 r1=0", in0_ready, in1_ready);
        end
        step();
        idle_inputs();
        step();
        @(negedge clk);
        check_empty("reset_mid_stall_done");
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                in1_valid = 1'b1;
                in1_data  = WIDTH'(i);
                sb.push_back({1'b1, WIDTH'(i)});
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            if (i < 8) begin
                checks++;
                if (in1_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got in1_ready=%0d, required 1", i, in1_ready);
                end
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_valid[%0d]: got out_valid=%0d, required 1", i, out_valid);
                end
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got out_valid=%0d, required 0", out_valid);
        end
        check_empty("back_to_back_done");
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_in0_only();
        test_reset();
        test_contention();
        test_backpressure();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
